// File: rtl/rvb_clmul_pkg.sv
// Shared definitions for the iterative carry-less multiply unit.
//   XLEN_DEFAULT : default operand/result width
//   FN_*         : function codes carried on io_req_bits_fn
//   state_e      : control FSM states (also exported on the debug port)
package rvb_clmul_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] FN_CLMUL  = 4'd0;
   localparam logic [3:0] FN_CLMULR = 4'd1;
   localparam logic [3:0] FN_CLMULH = 4'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/rvb_clmul_step.sv
// Combinational STEP-bit partial carry-less product.
//   acc       in   2*XLEN  running product
//   in1       in   XLEN    multiplicand
//   in2_slice in   STEP    multiplier bits for this iteration
//   base      in   BW      bit index of in2_slice[0] within the multiplier
//   acc_next  out  2*XLEN  acc XOR (in1 << (base+j)) for every set slice bit j
module rvb_clmul_step #(
   parameter int XLEN = 32,
   parameter int STEP = 1,
   parameter int BW   = $clog2(XLEN)
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   in1,
   input  logic [STEP-1:0]   in2_slice,
   input  logic [BW-1:0]     base,
   output logic [2*XLEN-1:0] acc_next
);

   always_comb begin
      acc_next = acc;
      for (int j = 0; j < STEP; j++) begin
         if (in2_slice[j]) begin
            acc_next = acc_next ^ ({{XLEN{1'b0}}, in1} << (int'(base) + j));
         end
      end
   end

endmodule

// File: rtl/rvb_clmul_iter.sv
// Iterative carry-less multiply unit (clmul / clmulr / clmulh).
// Responder on the req/resp handshake shared with the muldiv unit.
//   clock, reset           : single clock, synchronous active-high reset
//   io_req_*               : request (fn, in1, in2, tag); ready only in IDLE
//   io_kill                : abandons an op that is still in BUSY
//   io_resp_*              : result and echoed tag; valid only in DONE
//   dbg_state              : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; once valid is raised it and its payload hold until that edge.
// One op takes N = XLEN/STEP BUSY cycles, so the response is first valid
// N+1 cycles after the accept cycle.
module rvb_clmul_iter
   import rvb_clmul_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int STEP = 1
) (
   input  logic            clock,
   input  logic            reset,
   output logic            io_req_ready,
   input  logic            io_req_valid,
   input  logic [3:0]      io_req_bits_fn,
   input  logic [XLEN-1:0] io_req_bits_in1,
   input  logic [XLEN-1:0] io_req_bits_in2,
   input  logic [4:0]      io_req_bits_tag,
   input  logic            io_kill,
   input  logic            io_resp_ready,
   output logic            io_resp_valid,
   output logic [XLEN-1:0] io_resp_bits_data,
   output logic [4:0]      io_resp_bits_tag,
   output state_e          dbg_state
);

   localparam int N  = XLEN / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = $clog2(XLEN);

   state_e            state, state_next;
   logic [CW-1:0]     count;
   logic [2*XLEN-1:0] acc, acc_next;
   logic [XLEN-1:0]   in1_q, in2_q;
   logic [3:0]        fn_q;
   logic [4:0]        tag_q;
   logic [BW-1:0]     base;
   logic              last;

   assign base = BW'(int'(count) * STEP);
   assign last = (count == CW'(N - 1));

   rvb_clmul_step #(
      .XLEN (XLEN),
      .STEP (STEP),
      .BW   (BW)
   ) u_step (
      .acc       (acc),
      .in1       (in1_q),
      .in2_slice (in2_q[base +: STEP]),
      .base      (base),
      .acc_next  (acc_next)
   );

   // Kill only matters while computing; a finished result is always delivered.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (io_req_valid) state_next = BUSY;
         BUSY: begin
            if (io_kill)   state_next = IDLE;
            else if (last) state_next = DONE;
         end
         DONE:    if (io_resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         acc   <= '0;
         in1_q <= '0;
         in2_q <= '0;
         fn_q  <= '0;
         tag_q <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (io_req_valid) begin
                  in1_q <= io_req_bits_in1;
                  in2_q <= io_req_bits_in2;
                  fn_q  <= io_req_bits_fn;
                  tag_q <= io_req_bits_tag;
                  acc   <= '0;
                  count <= '0;
               end
            end
            BUSY: begin
               acc   <= acc_next;
               count <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // clmulr is the full product shifted right by XLEN-1.
   always_comb begin
      case (fn_q)
         FN_CLMUL:  io_resp_bits_data = acc[XLEN-1:0];
         FN_CLMULH: io_resp_bits_data = acc[2*XLEN-1:XLEN];
         FN_CLMULR: io_resp_bits_data = acc[2*XLEN-2:XLEN-1];
         default:   io_resp_bits_data = '0;
      endcase
   end

   assign io_req_ready     = (state == IDLE);
   assign io_resp_valid    = (state == DONE);
   assign io_resp_bits_tag = tag_q;
   assign dbg_state        = state;

endmodule

// File: tb/tb_rvb_clmul_iter.sv
module tb_rvb_clmul_iter;
   import rvb_clmul_pkg::*;

   localparam int XLEN = 32;
   localparam int STEP = 1;
   localparam int N    = XLEN / STEP;
   localparam int WAIT_MAX = 4 * N + 20;

   // ---------------- clock / reset ----------------
   logic            clock = 1'b0;
   logic            reset;
   logic            req_ready, req_valid;
   logic [3:0]      req_fn;
   logic [XLEN-1:0] req_in1, req_in2;
   logic [4:0]      req_tag;
   logic            kill;
   logic            resp_ready, resp_valid;
   logic [XLEN-1:0] resp_data;
   logic [4:0]      resp_tag;
   state_e          dbg_state;

   always #5 clock = ~clock;

   rvb_clmul_iter #(.XLEN(XLEN), .STEP(STEP)) dut (
      .clock             (clock),
      .reset             (reset),
      .io_req_ready      (req_ready),
      .io_req_valid      (req_valid),
      .io_req_bits_fn    (req_fn),
      .io_req_bits_in1   (req_in1),
      .io_req_bits_in2   (req_in2),
      .io_req_bits_tag   (req_tag),
      .io_kill           (kill),
      .io_resp_ready     (resp_ready),
      .io_resp_valid     (resp_valid),
      .io_resp_bits_data (resp_data),
      .io_resp_bits_tag  (resp_tag),
      .dbg_state         (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [4:0]      tag_q[$];

   // Reference: product bit k is the XOR of a[i]&b[j] over all i+j==k.
   function automatic logic [XLEN-1:0] ref_clmul(input logic [3:0] fn,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] p;
      p = '0;
      for (int k = 0; k < 2*XLEN - 1; k++) begin
         logic bitk;
         bitk = 1'b0;
         for (int i = 0; i < XLEN; i++) begin
            if (k - i >= 0 && k - i < XLEN) bitk = bitk ^ (a[i] & b[k-i]);
         end
         p[k] = bitk;
      end
      case (fn)
         4'd0:    return p[XLEN-1:0];
         4'd2:    return p[2*XLEN-1:XLEN];
         4'd1:    return p[2*XLEN-2:XLEN-1];
         default: return '0;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 1'b0; req_fn = '0; req_in1 = '0; req_in2 = '0; req_tag = '0;
      kill = 1'b0; resp_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic start_req(input string name, input logic [3:0] fn,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [4:0] tag);
      checks++;
      if (req_ready !== 1'b1)
         $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
      req_valid = 1'b1; req_fn = fn; req_in1 = a; req_in2 = b; req_tag = tag;
      exp_q.push_back(ref_clmul(fn, a, b));
      tag_q.push_back(tag);
      cycle();
      // Scramble inputs: they must no longer matter.
      req_valid = 1'b0;
      req_fn  = 4'($urandom);
      req_in1 = $urandom;
      req_in2 = $urandom;
      req_tag = 5'($urandom);
   endtask

   task automatic wait_resp(input string name, output bit got);
      int lat;
      lat = 0;
      while (resp_valid !== 1'b1 && lat <= WAIT_MAX) begin
         cycle();
         lat++;
      end
      checks++;
      got = (resp_valid === 1'b1);
      if (!got)
         $display("FAIL %s timeout: no resp_valid after %0d cycles", name, lat);
      else if (lat != N)
         $display("FAIL %s latency: got %0d cycles after accept want %0d", name, lat, N);
      if (!got || lat != N) errors++;
   endtask

   // Holds resp_ready low for 'hold' cycles (kill toggled randomly, must be
   // ignored), then completes the handshake.
   task automatic take_resp(input string name, input int hold);
      logic [XLEN-1:0] e;
      logic [4:0]      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      for (int c = 0; c < hold; c++) begin
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== e || resp_tag !== t || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold cycle %0d: valid=%b data=%h tag=%0d req_ready=%b want valid=1 data=%h tag=%0d req_ready=0",
                     name, c, resp_valid, resp_data, resp_tag, req_ready, e, t);
         end
         kill = 1'($urandom_range(0, 1));
         cycle();
      end
      kill = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e || resp_tag !== t) begin
         errors++;
         $display("FAIL %s data: valid=%b data=%h tag=%0d want valid=1 data=%h tag=%0d",
                  name, resp_valid, resp_data, resp_tag, e, t);
      end
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s after handshake: req_ready=%b resp_valid=%b want 1 0",
                  name, req_ready, resp_valid);
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] fn,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] tag, input int hold);
      bit got;
      if (req_ready !== 1'b1) errors++;
      start_req(name, fn, a, b, tag);
      wait_resp(name, got);
      if (got) take_resp(name, hold);
      else begin
         void'(exp_q.pop_front());
         void'(tag_q.pop_front());
      end
   endtask

   // Watches for a stray response over 'n' cycles.
   task automatic expect_silence(input string name, input int n);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (resp_valid !== 1'b0) seen = 1'b1;
         cycle();
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL %s stray response: resp_valid seen 1 want 0", name);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset state: req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_directed();
      run_op("clmul_3x3",   4'd0, 32'd3,        32'd3,        5'd17, 0);
      run_op("clmulh_msb",  4'd2, 32'h80000000, 32'h80000000, 5'd1,  0);
      run_op("clmulr_msb",  4'd1, 32'h80000000, 32'h80000000, 5'd2,  0);
      run_op("clmul_msb",   4'd0, 32'h80000000, 32'h80000000, 5'd3,  0);
      run_op("reserved_7",  4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  0);
      run_op("zero_in1",    4'd0, 32'h0,        32'h12345678, 5'd5,  0);
      run_op("zero_in2",    4'd2, 32'hDEADBEEF, 32'h0,        5'd6,  0);
      run_op("ones_clmulh", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  0);
   endtask

   task automatic test_backpressure();
      run_op("backpressure", 4'd0, 32'hA5A5_1234, 32'h0F0F_8001, 5'd31, 10);
   endtask

   task automatic test_kill();
      if (req_ready !== 1'b1) errors++;
      // Kill in IDLE has no effect.
      kill = 1'b1;
      cycle();
      kill = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL kill_idle: req_ready=%b want 1", req_ready);
      end
      start_req("kill", 4'd0, 32'hFFFF_FFFF, 32'h1234_5678, 5'd9);
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
      repeat (4) cycle();
      kill = 1'b1;
      cycle();
      kill = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL kill_busy: req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
      end
      expect_silence("kill", N + 5);
      run_op("after_kill", 4'd0, 32'hF, 32'h2, 5'd10, 0);
   endtask

   task automatic test_reset_mid();
      start_req("reset_mid", 4'd2, 32'hCAFE_F00D, 32'hBEEF_0001, 5'd12);
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
      repeat (9) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
      end
      expect_silence("reset_mid", N + 5);
      run_op("after_reset", 4'd1, 32'h0000_00FF, 32'h8000_0001, 5'd13, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 24; r++) begin
         logic [3:0] fn;
         fn = (r % 8 == 7) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
         run_op("random", fn, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3));
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 4; r++)
         run_op("back_to_back", 4'(r % 3), $urandom, $urandom, 5'(r), 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
